// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and
// the helper used to size the iteration counter.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } mult_state_t;

    // Ceiling log2; clog2(WIDTH+1) gives a counter able to hold 0..WIDTH.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 40; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Datapath of the shift-add multiplier: operand magnitudes, shifting
// multiplicand/multiplier, accumulator, iteration counter and product register.
module shift_add_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rstN,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_finish,
    input  logic               i_signedMode,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_prod,
    output logic               o_multZero,
    output logic               o_countMax
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = clog2(WIDTH + 1);

    logic [WIDTH-1:0] w_magA;
    logic [WIDTH-1:0] w_magB;

    logic [PW-1:0]    r_multCand;
    logic [WIDTH-1:0] r_mult;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_count;
    logic             r_neg;
    logic [PW-1:0]    r_prod;

    // The most negative value negates to itself, which read as unsigned is 2^(WIDTH-1).
    assign w_magA = (i_signedMode && i_a[WIDTH-1]) ? (~i_a + WIDTH'(1)) : i_a;
    assign w_magB = (i_signedMode && i_b[WIDTH-1]) ? (~i_b + WIDTH'(1)) : i_b;

    // Status looks ahead at the values the current step produces, so the
    // controller can leave RUN right after the cycle that exhausts the multiplier.
    assign o_multZero = (r_mult[WIDTH-1:1] == '0);
    assign o_countMax = (r_count == CW'(WIDTH - 1));
    assign o_prod     = r_prod;

    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_multCand <= '0;
            r_mult     <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_neg      <= 1'b0;
            r_prod     <= '0;
        end else if (i_load) begin
            r_multCand <= {{WIDTH{1'b0}}, w_magA};
            r_mult     <= w_magB;
            r_acc      <= '0;
            r_count    <= '0;
            r_neg      <= i_signedMode & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        end else if (i_step) begin
            if (r_mult[0]) begin
                r_acc <= r_acc + r_multCand;
            end
            r_multCand <= r_multCand << 1;
            r_mult     <= r_mult >> 1;
            r_count    <= r_count + CW'(1);
        end else if (i_finish) begin
            r_prod <= r_neg ? (~r_acc + PW'(1)) : r_acc;
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential signed/unsigned shift-add multiplier: FSM control wrapped around
// shift_add_datapath, with early termination once the multiplier runs out of ones.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic               SIGNED_MODE,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P,
    output logic               BUSY,
    output logic               DONE
);

    mult_state_t r_state;
    mult_state_t w_nextState;
    logic        w_load;
    logic        w_step;
    logic        w_finish;
    logic        w_multZero;
    logic        w_countMax;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operands are only captured in IDLE, so START and operand changes while busy are inert.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_load      = 1'b1;
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_multZero || w_countMax) begin
                    w_nextState = ST_SIGN;
                end
            end
            ST_SIGN: begin
                w_finish    = 1'b1;
                w_nextState = ST_DONE;
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign BUSY = (r_state != ST_IDLE);
    assign DONE = (r_state == ST_DONE);

    shift_add_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .i_clk       (CLK),
        .i_rstN      (RST_N),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_finish    (w_finish),
        .i_signedMode(SIGNED_MODE),
        .i_a         (A),
        .i_b         (B),
        .o_prod      (P),
        .o_multZero  (w_multZero),
        .o_countMax  (w_countMax)
    );

endmodule
